// File: rtl/kbd_uart_rx.sv
// LC-3 keyboard receive path: 8N1 UART deserialiser feeding KBDR/KBSR.
// KBSR = {ready, interrupt-enable, overrun, 13'b0}; ready is cleared by a KBDR read.
module kbd_uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        i_Clk,
  input  logic        reset_,
  input  logic        i_Rx_Serial,
  input  logic        rd_kbdr,
  input  logic        ld_kbsr,
  input  logic [15:0] kbsr_in,
  output logic [15:0] kbdr,
  output logic [15:0] kbsr,
  output logic        kb_irq,
  output logic        rx_busy,
  output logic        framing_err,
  output logic [2:0]  o_dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_sync1;
  logic            r_rx_s;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_byte;
  logic            r_ready;
  logic            r_ie;
  logic            r_ovr;
  logic            r_ferr;
  logic            w_half;
  logic            w_done;
  logic            w_sample;
  logic            w_commit;
  logic            w_ferr;

  assign w_half = (r_cnt == HALF);
  assign w_done = (r_cnt == LAST);

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge i_Clk or negedge reset_) begin
    if (!reset_) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= i_Rx_Serial;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge i_Clk or negedge reset_) begin
    if (!reset_) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (!r_rx_s) w_next = S_START;
      S_START:   if (w_half) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:    if (w_done && (r_idx == 3'd7)) w_next = S_STOP;
      S_STOP:    if (w_done) w_next = S_CLEANUP;
      S_CLEANUP: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_busy  = (r_state != S_IDLE);
    w_sample = (r_state == S_DATA) && w_done;
    w_commit = (r_state == S_STOP) && w_done && r_rx_s;
    w_ferr   = (r_state == S_STOP) && w_done && !r_rx_s;
  end

  always_ff @(posedge i_Clk or negedge reset_) begin
    if (!reset_) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      case (r_state)
        S_START:        r_cnt <= w_half ? '0 : r_cnt + CW'(1);
        S_DATA, S_STOP: r_cnt <= w_done ? '0 : r_cnt + CW'(1);
        default:        r_cnt <= '0;
      endcase
      if (r_state == S_IDLE) r_idx <= 3'd0;
      else if (w_sample)     r_idx <= r_idx + 3'd1;
      if (w_sample) r_shift[r_idx] <= r_rx_s;
    end
  end

  // A commit beats a simultaneous read; overrun beats a software clear.
  always_ff @(posedge i_Clk or negedge reset_) begin
    if (!reset_) begin
      r_byte  <= 8'h00;
      r_ready <= 1'b0;
      r_ie    <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      if (w_commit)     r_byte <= r_shift;
      if (w_commit)     r_ready <= 1'b1;
      else if (rd_kbdr) r_ready <= 1'b0;
      if (ld_kbsr)      r_ie <= kbsr_in[14];
      if (w_commit && r_ready && !rd_kbdr) r_ovr <= 1'b1;
      else if (ld_kbsr)                    r_ovr <= kbsr_in[13];
    end
  end

  assign kbdr        = {8'h00, r_byte};
  assign kbsr        = {r_ready, r_ie, r_ovr, 13'b0};
  assign kb_irq      = r_ready & r_ie;
  assign framing_err = r_ferr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_kbd_uart_rx.sv
// Bench for kbd_uart_rx: drives 8N1 frames at CLKS_PER_BIT=8 and checks KBDR/KBSR
// against a queue of expected bytes and a small model of the status register.
module tb_kbd_uart_rx;

  localparam int CPB      = 8;
  localparam int FRAME    = 10 * CPB;
  localparam int COMMIT_C = 3 + (CPB - 1) / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        rx = 1'b1;
  logic        rd_kbdr = 1'b0;
  logic        ld_kbsr = 1'b0;
  logic [15:0] kbsr_in = 16'h0000;
  logic [15:0] kbdr;
  logic [15:0] kbsr;
  logic        kb_irq;
  logic        rx_busy;
  logic        framing_err;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int busy_low = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp_kbdr;
  logic        m_ready = 1'b0;
  logic        m_ie = 1'b0;
  logic        m_ovr = 1'b0;
  logic [15:0] m_kbdr = 16'h0000;

  kbd_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clk(clk), .reset_(reset_), .i_Rx_Serial(rx), .rd_kbdr(rd_kbdr),
    .ld_kbsr(ld_kbsr), .kbsr_in(kbsr_in), .kbdr(kbdr), .kbsr(kbsr),
    .kb_irq(kb_irq), .rx_busy(rx_busy), .framing_err(framing_err),
    .o_dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  always @(negedge clk) if (framing_err) ferr_cnt++;

  function automatic logic [15:0] m_kbsr();
    return {m_ready, m_ie, m_ovr, 13'b0};
  endfunction

  // driver tasks: every task starts and ends 1 time unit after a rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rd_cycle);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    if (stop_bit) exp_q.push_back({8'h00, b});
    busy_low = 0;
    for (int c = 0; c < FRAME; c++) begin
      rx      = bits[c / CPB];
      rd_kbdr = (c == rd_cycle);
      tick(1);
      if (c >= 4 && c <= FRAME - 4 && !rx_busy) busy_low++;
    end
    rd_kbdr = 1'b0;
    rx      = 1'b1;
    if (stop_bit) begin
      if (m_ready && rd_cycle != COMMIT_C) m_ovr = 1'b1;
      m_ready = 1'b1;
      m_kbdr  = {8'h00, b};
    end else if (rd_cycle >= 0) begin
      m_ready = 1'b0;
    end
  endtask

  task automatic pulse_rd();
    rd_kbdr = 1'b1;
    tick(1);
    rd_kbdr = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic write_kbsr(input logic [15:0] v);
    ld_kbsr = 1'b1;
    kbsr_in = v;
    tick(1);
    ld_kbsr = 1'b0;
    kbsr_in = 16'h0000;
    m_ie    = v[14];
    m_ovr   = v[13];
  endtask

  task automatic pop_exp(output logic [15:0] e);
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL queue_empty: no expected byte queued for a commit");
      e = 16'hxxxx;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    rx     = 1'b1;
    tick(3);
    checks++;
    if ({kbdr, kbsr, rx_busy, framing_err, kb_irq, dbg_state} !== 38'h0) begin
      failures++;
      $display("FAIL reset_vals: kbdr=%h kbsr=%h busy=%b ferr=%b irq=%b st=%0d, required all 0",
               kbdr, kbsr, rx_busy, framing_err, kb_irq, dbg_state);
    end
    reset_ = 1'b1;
    tick(3);
  endtask

  task automatic test_single();
    send_frame(8'h41, 1'b1, -1);
    pop_exp(exp_kbdr);
    checks++;
    if (kbdr !== exp_kbdr) begin
      failures++; $display("FAIL single_kbdr: got %h, required %h", kbdr, exp_kbdr);
    end
    checks++;
    if (kbsr !== m_kbsr()) begin
      failures++; $display("FAIL single_kbsr: got %h, required %h", kbsr, m_kbsr());
    end
    checks++;
    if (busy_low !== 0) begin
      failures++; $display("FAIL single_busy: rx_busy low for %0d cycles, required 0", busy_low);
    end
    tick(2);
  endtask

  task automatic test_overrun();
    pulse_rd();
    checks++;
    if (kbsr !== m_kbsr()) begin
      failures++; $display("FAIL rd_clear: kbsr got %h, required %h", kbsr, m_kbsr());
    end
    send_frame(8'hA5, 1'b1, -1);
    pop_exp(exp_kbdr);
    checks++;
    if ({kbdr, kbsr} !== {exp_kbdr, m_kbsr()}) begin
      failures++;
      $display("FAIL byte_a5: kbdr/kbsr got %h/%h, required %h/%h", kbdr, kbsr, exp_kbdr, m_kbsr());
    end
    send_frame(8'h3C, 1'b1, -1);
    pop_exp(exp_kbdr);
    checks++;
    if ({kbdr, kbsr} !== {exp_kbdr, m_kbsr()}) begin
      failures++;
      $display("FAIL overrun: kbdr/kbsr got %h/%h, required %h/%h", kbdr, kbsr, exp_kbdr, m_kbsr());
    end
    write_kbsr(16'h0000);
    checks++;
    if (kbsr !== m_kbsr()) begin
      failures++; $display("FAIL ovr_clear: kbsr got %h, required %h", kbsr, m_kbsr());
    end
  endtask

  task automatic test_glitch();
    int f0;
    int saw_busy;
    f0       = ferr_cnt;
    saw_busy = 0;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (rx_busy) saw_busy++;
    end
    checks++;
    if (saw_busy == 0 || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL glitch_fsm: busy cycles=%0d state=%0d, required >0 and state 0", saw_busy, dbg_state);
    end
    checks++;
    if ({kbdr, kbsr} !== {m_kbdr, m_kbsr()} || ferr_cnt !== f0) begin
      failures++;
      $display("FAIL glitch_regs: kbdr/kbsr/ferr got %h/%h/%0d, required %h/%h/%0d",
               kbdr, kbsr, ferr_cnt, m_kbdr, m_kbsr(), f0);
    end
  endtask

  task automatic test_framing();
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, -1);
    tick(20);
    checks++;
    if (ferr_cnt !== f0 + 1) begin
      failures++; $display("FAIL ferr_pulse: pulse cycles got %0d, required %0d", ferr_cnt - f0, 1);
    end
    checks++;
    if ({kbdr, kbsr, dbg_state} !== {m_kbdr, m_kbsr(), 3'd0}) begin
      failures++;
      $display("FAIL ferr_regs: kbdr/kbsr/st got %h/%h/%0d, required %h/%h/0", kbdr, kbsr, dbg_state, m_kbdr, m_kbsr());
    end
  endtask

  task automatic test_irq();
    write_kbsr(16'h4000);
    pulse_rd();
    send_frame(8'h0D, 1'b1, -1);
    pop_exp(exp_kbdr);
    checks++;
    if ({kbdr, kbsr, kb_irq} !== {exp_kbdr, m_kbsr(), m_ready & m_ie}) begin
      failures++;
      $display("FAIL irq: kbdr/kbsr/irq got %h/%h/%b, required %h/%h/%b",
               kbdr, kbsr, kb_irq, exp_kbdr, m_kbsr(), m_ready & m_ie);
    end
    send_frame(8'h0A, 1'b1, COMMIT_C);
    pop_exp(exp_kbdr);
    checks++;
    if ({kbdr, kbsr} !== {exp_kbdr, m_kbsr()}) begin
      failures++;
      $display("FAIL rd_vs_commit: kbdr/kbsr got %h/%h, required %h/%h", kbdr, kbsr, exp_kbdr, m_kbsr());
    end
  endtask

  task automatic test_back_to_back();
    write_kbsr(16'h0000);
    pulse_rd();
    send_frame(8'h11, 1'b1, -1);
    pop_exp(exp_kbdr);
    checks++;
    if ({kbdr, kbsr} !== {exp_kbdr, m_kbsr()}) begin
      failures++;
      $display("FAIL b2b_first: kbdr/kbsr got %h/%h, required %h/%h", kbdr, kbsr, exp_kbdr, m_kbsr());
    end
    send_frame(8'hE2, 1'b1, -1);
    pop_exp(exp_kbdr);
    checks++;
    if ({kbdr, kbsr, busy_low} !== {exp_kbdr, m_kbsr(), 32'd0}) begin
      failures++;
      $display("FAIL b2b_second: kbdr/kbsr/busy_low got %h/%h/%0d, required %h/%h/0",
               kbdr, kbsr, busy_low, exp_kbdr, m_kbsr());
    end
    tick(3);
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    bits = {1'b1, 8'hC3, 1'b0};
    for (int c = 0; c < 30; c++) begin
      rx = bits[c / CPB];
      tick(1);
    end
    #2 reset_ = 1'b0;
    #1;
    checks++;
    if ({kbdr, kbsr, rx_busy, framing_err, kb_irq, dbg_state} !== 38'h0) begin
      failures++;
      $display("FAIL async_reset: kbdr=%h kbsr=%h busy=%b ferr=%b irq=%b st=%0d, required all 0",
               kbdr, kbsr, rx_busy, framing_err, kb_irq, dbg_state);
    end
    rx      = 1'b1;
    m_ready = 1'b0;
    m_ie    = 1'b0;
    m_ovr   = 1'b0;
    m_kbdr  = 16'h0000;
    exp_q.delete();
    tick(3);
    reset_ = 1'b1;
    tick(3);
    send_frame(8'h7E, 1'b1, -1);
    pop_exp(exp_kbdr);
    checks++;
    if ({kbdr, kbsr} !== {exp_kbdr, m_kbsr()}) begin
      failures++;
      $display("FAIL after_reset: kbdr/kbsr got %h/%h, required %h/%h", kbdr, kbsr, exp_kbdr, m_kbsr());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_glitch();
    test_framing();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL leftover_queue: %0d expected bytes never checked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
